// File: rtl/comparador_iterativo.sv
// comparador_iterativo: multi-cycle magnitude comparator.
//
// Compares two WIDTH-bit operands CHUNK bits per cycle, most significant chunk first, and stops
// at the first chunk that differs. Signed or unsigned order is selected per operation.
// Result encoding is one-hot: 001 greater, 010 equal, 100 less; 000 only before the first result.
//
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   start              request, sampled only while in_ready is high
//   signed_mode        1 = two's-complement compare, 0 = unsigned; latched with the operands
//   input1, input2     operands A and B
//   clear_counts       synchronous clear of all event counters (wins over an increment)
//   in_ready           high while idle
//   done               one-cycle pulse when output_comparador holds a fresh result
//   output_comparador  one-hot result of A vs B, held until the next done
//   cnt_gt/eq/lt       saturating counts of each result kind
module comparador_iterativo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             clear_counts,
  output logic             in_ready,
  output logic             done,
  output logic [2:0]       output_comparador,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_lt
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCHUNK - 1);

  localparam logic [2:0] ResGt = 3'b001;
  localparam logic [2:0] ResEq = 3'b010;
  localparam logic [2:0] ResLt = 3'b100;

  typedef enum logic [1:0] {
    StIdle,
    StCompare,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [2:0]       res_q, res_d;
  logic [CNT_W-1:0] cnt_gt_q, cnt_gt_d;
  logic [CNT_W-1:0] cnt_eq_q, cnt_eq_d;
  logic [CNT_W-1:0] cnt_lt_q, cnt_lt_d;

  logic             finish;
  logic [WIDTH-1:0] sign_flip;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;

  // Flipping both MSBs maps two's-complement order onto unsigned order.
  assign sign_flip = {signed_mode, {(WIDTH - 1){1'b0}}};

  // Operands are shifted left after each equal chunk, so the current chunk is always on top.
  assign chunk_a = a_q[WIDTH-1 -: CHUNK];
  assign chunk_b = b_q[WIDTH-1 -: CHUNK];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    res_d   = res_q;
    finish  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = input1 ^ sign_flip;
          b_d     = input2 ^ sign_flip;
          idx_d   = '0;
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (chunk_a > chunk_b) begin
          res_d  = ResGt;
          finish = 1'b1;
        end else if (chunk_a < chunk_b) begin
          res_d  = ResLt;
          finish = 1'b1;
        end else if (idx_q == LastIdx) begin
          res_d  = ResEq;
          finish = 1'b1;
        end else begin
          idx_d = idx_q + IdxW'(1);
          a_d   = a_q << CHUNK;
          b_d   = b_q << CHUNK;
        end
        if (finish) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Saturating counters; clear takes priority over a coincident increment.
  always_comb begin
    cnt_gt_d = cnt_gt_q;
    cnt_eq_d = cnt_eq_q;
    cnt_lt_d = cnt_lt_q;
    if (clear_counts) begin
      cnt_gt_d = '0;
      cnt_eq_d = '0;
      cnt_lt_d = '0;
    end else if (finish) begin
      if (res_d == ResGt && cnt_gt_q != '1) cnt_gt_d = cnt_gt_q + CNT_W'(1);
      if (res_d == ResEq && cnt_eq_q != '1) cnt_eq_d = cnt_eq_q + CNT_W'(1);
      if (res_d == ResLt && cnt_lt_q != '1) cnt_lt_d = cnt_lt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      res_q    <= '0;
      cnt_gt_q <= '0;
      cnt_eq_q <= '0;
      cnt_lt_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      res_q    <= res_d;
      cnt_gt_q <= cnt_gt_d;
      cnt_eq_q <= cnt_eq_d;
      cnt_lt_q <= cnt_lt_d;
    end
  end

  assign in_ready          = (state_q == StIdle);
  assign done              = (state_q == StDone);
  assign output_comparador = res_q;
  assign cnt_gt            = cnt_gt_q;
  assign cnt_eq            = cnt_eq_q;
  assign cnt_lt            = cnt_lt_q;

endmodule

// File: tb/tb_comparador_iterativo.sv
// Testbench for comparador_iterativo (WIDTH=16, CHUNK=4, CNT_W=2 so saturation is reachable).
module tb_comparador_iterativo;

  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          signed_mode = 1'b0;
  logic [15:0]   input1 = '0;
  logic [15:0]   input2 = '0;
  logic          clear_counts = 1'b0;
  logic          in_ready;
  logic          done;
  logic [2:0]    output_comparador;
  logic [CW-1:0] cnt_gt;
  logic [CW-1:0] cnt_eq;
  logic [CW-1:0] cnt_lt;

  comparador_iterativo #(
    .WIDTH(16),
    .CHUNK(4),
    .CNT_W(CW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .signed_mode      (signed_mode),
    .input1           (input1),
    .input2           (input2),
    .clear_counts     (clear_counts),
    .in_ready         (in_ready),
    .done             (done),
    .output_comparador(output_comparador),
    .cnt_gt           (cnt_gt),
    .cnt_eq           (cnt_eq),
    .cnt_lt           (cnt_lt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic        tog;
    logic [2:0]  exp;
    int          n;
  } vec_t;

  vec_t vecs[12];

  task automatic clear_cnt();
    @(negedge clk);
    clear_counts = 1'b1;
    @(negedge clk);
    clear_counts = 1'b0;
  endtask

  // Leaves the caller at a negedge with in_ready high (or a recorded failure).
  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Runs one operation; returns cycles from accept edge to visible done, and the result.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sm,
                        input logic tog, output int lat, output logic [2:0] res);
    lat = -1;
    wait_ready();
    input1      = a;
    input2      = b;
    signed_mode = sm;
    start       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      check("busy_not_ready", 32'(in_ready), 32'd0);
      if (tog) begin
        input1      = 16'($urandom);
        input2      = 16'($urandom);
        signed_mode = ~signed_mode;
      end
    end
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
    res = output_comparador;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int          lat;
    logic [2:0]  res;
    logic [2:0]  last;
    logic [2:0]  q[$];
    logic [2:0]  e;
    int          accepts;
    int          dones;
    int          next_acc;
    int          sel;

    vecs[0]  = '{16'h1234, 16'h1234, 1'b0, 1'b0, 3'b010, 4};
    vecs[1]  = '{16'h8000, 16'h0001, 1'b0, 1'b0, 3'b001, 1};
    vecs[2]  = '{16'h8000, 16'h0001, 1'b1, 1'b0, 3'b100, 1};
    vecs[3]  = '{16'h1235, 16'h1234, 1'b0, 1'b0, 3'b001, 4};
    vecs[4]  = '{16'h1204, 16'h1234, 1'b0, 1'b0, 3'b100, 3};
    vecs[5]  = '{16'h1235, 16'h1234, 1'b0, 1'b1, 3'b001, 4};
    vecs[6]  = '{16'h1204, 16'h1234, 1'b0, 1'b1, 3'b100, 3};
    vecs[7]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 3'b100, 1};
    vecs[8]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 3'b010, 4};
    vecs[9]  = '{16'h7FFF, 16'h8000, 1'b1, 1'b0, 3'b001, 1};
    vecs[10] = '{16'h1034, 16'h1234, 1'b0, 1'b0, 3'b100, 2};
    vecs[11] = '{16'hABCD, 16'hABC0, 1'b1, 1'b0, 3'b001, 4};

    // Power-on reset
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(output_comparador), 32'd0);
    check("rst_counts", {cnt_gt, cnt_eq, cnt_lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, counters cleared before each one
    for (int v = 0; v < 12; v++) begin
      clear_cnt();
      run_op(vecs[v].a, vecs[v].b, vecs[v].sm, vecs[v].tog, lat, res);
      check($sformatf("v%0d_result", v), 32'(res), 32'(vecs[v].exp));
      check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].n));
      check($sformatf("v%0d_cnt_gt", v), 32'(cnt_gt), 32'(vecs[v].exp == 3'b001));
      check($sformatf("v%0d_cnt_eq", v), 32'(cnt_eq), 32'(vecs[v].exp == 3'b010));
      check($sformatf("v%0d_cnt_lt", v), 32'(cnt_lt), 32'(vecs[v].exp == 3'b100));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", v), 32'(done), 32'd0);
      check($sformatf("v%0d_ready_again", v), 32'(in_ready), 32'd1);
      check($sformatf("v%0d_result_held", v), 32'(output_comparador), 32'(vecs[v].exp));
    end
    last = vecs[11].exp;

    // Handshake: start held high; a model predicts every accept cycle independently
    accepts  = 0;
    dones    = 0;
    next_acc = 0;
    start    = 1'b1;
    signed_mode = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      sel = (cyc / 2) % 2;
      if (sel == 0) begin
        input1 = 16'h1235;
        input2 = 16'h1234;
      end else begin
        input1 = 16'h0001;
        input2 = 16'h8000;
      end
      check("hs_ready", 32'(in_ready), 32'(cyc == next_acc));
      if (cyc == next_acc) begin
        accepts++;
        q.push_back((sel == 0) ? 3'b001 : 3'b100);
        next_acc = cyc + ((sel == 0) ? 4 : 1) + 2;
      end
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        if (q.size() == 0) begin
          check("hs_spurious_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("hs_result", 32'(output_comparador), 32'(e));
          last = e;
        end
      end else begin
        check("hs_hold", 32'(output_comparador), 32'(last));
      end
    end
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        if (q.size() != 0) begin
          e = q.pop_front();
          check("hs_drain_result", 32'(output_comparador), 32'(e));
        end
      end
    end
    check("hs_accepts_vs_dones", 32'(dones), 32'(accepts));

    // Reset in the middle of a comparison
    wait_ready();
    input1 = 16'h1234;
    input2 = 16'h1234;
    signed_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(output_comparador), 32'd0);
    check("midrst_counts", {cnt_gt, cnt_eq, cnt_lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check("midrst_no_done", 32'(done), 32'd0);
    end

    // Saturation at 3 and clear winning over a coincident increment
    clear_cnt();
    for (int k = 0; k < 5; k++) begin
      run_op(16'h8000, 16'h0001, 1'b0, 1'b0, lat, res);
    end
    check("sat_cnt_gt", 32'(cnt_gt), 32'd3);
    check("sat_cnt_eq", 32'(cnt_eq), 32'd0);
    run_op(16'h0001, 16'h8000, 1'b0, 1'b0, lat, res);
    check("sat_lt_result", 32'(res), 32'b100);
    check("sat_cnt_lt", 32'(cnt_lt), 32'd1);
    wait_ready();
    input1 = 16'h8000;
    input2 = 16'h0001;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    clear_counts = 1'b1;
    @(posedge clk);
    #1;
    check("clr_done", 32'(done), 32'd1);
    check("clr_result", 32'(output_comparador), 32'b001);
    check("clr_cnt_gt", 32'(cnt_gt), 32'd0);
    check("clr_cnt_lt", 32'(cnt_lt), 32'd0);
    @(negedge clk);
    clear_counts = 1'b0;
    @(posedge clk);
    #1;
    check("clr_result_held", 32'(output_comparador), 32'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
